// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped branch history table with 2-bit saturating
//             counters. It gives a combinational taken/not-taken guess for
//             the FD-stage branch and is trained by the resolved X-stage
//             branch. It also keeps branch and mispredict statistics.
//  Options  : BP_FWD_EN - forward a same-cycle, same-index update into the
//             guess path (adds a check-to-prediction combinational path).
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int PC_WIDTH  = 32,
   parameter int LINES     = 8,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PC_WIDTH-1:0]  pc_guess,
   input  logic                 is_br_guess,
   output logic                 pred_taken,
   input  logic [PC_WIDTH-1:0]  pc_check,
   input  logic                 is_br_check,
   input  logic                 br_taken_check,
   input  logic                 pred_taken_check,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Table storage
   logic             valid_mem [LINES];
   logic [TAG_W-1:0] tag_mem   [LINES];
   logic [1:0]       cnt_mem   [LINES];

   // Address decomposition; PC bits [1:0] never take part in lookup
   logic [IDX_W-1:0] guess_idx;
   logic [TAG_W-1:0] guess_tag;
   logic [IDX_W-1:0] check_idx;
   logic [TAG_W-1:0] check_tag;
   logic             unused_pc_lsbs;

   assign guess_idx      = pc_guess[2 +: IDX_W];
   assign guess_tag      = pc_guess[PC_WIDTH-1 : 2+IDX_W];
   assign check_idx      = pc_check[2 +: IDX_W];
   assign check_tag      = pc_check[PC_WIDTH-1 : 2+IDX_W];
   assign unused_pc_lsbs = ^{pc_guess[1:0], pc_check[1:0]};

   // Training side: hit detection and the counter value to be written
   logic       check_hit;
   logic [1:0] new_cnt;

   assign check_hit = valid_mem[check_idx] && (tag_mem[check_idx] == check_tag);

   // Saturating step on a hit, fresh weak state on allocation
   always_comb begin
      new_cnt = CNT_WNT;
      if (check_hit) begin
         if (br_taken_check)
            new_cnt = (cnt_mem[check_idx] == CNT_ST) ? CNT_ST
                                                     : cnt_mem[check_idx] + 2'd1;
         else
            new_cnt = (cnt_mem[check_idx] == CNT_SNT) ? CNT_SNT
                                                      : cnt_mem[check_idx] - 2'd1;
      end else begin
         new_cnt = br_taken_check ? CNT_WT : CNT_WNT;
      end
   end

   // Guess side: pick the entry the prediction is evaluated against
   logic             sel_valid;
   logic [TAG_W-1:0] sel_tag;
   logic [1:0]       sel_cnt;

`ifdef BP_FWD_EN
   // A same-index update in flight is seen by the guess as already written
   always_comb begin
      sel_valid = valid_mem[guess_idx];
      sel_tag   = tag_mem[guess_idx];
      sel_cnt   = cnt_mem[guess_idx];
      if (!rst && is_br_check && (check_idx == guess_idx)) begin
         sel_valid = 1'b1;
         sel_tag   = check_tag;
         sel_cnt   = new_cnt;
      end
   end
`else
   // Guess always reads stored state; a same-cycle update is not visible
   always_comb begin
      sel_valid = valid_mem[guess_idx];
      sel_tag   = tag_mem[guess_idx];
      sel_cnt   = cnt_mem[guess_idx];
   end
`endif

   assign pred_taken = is_br_guess && sel_valid && (sel_tag == guess_tag) && sel_cnt[1];

   // Table update: reset clears every line, a resolved branch trains or allocates
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++) begin
            valid_mem[i] <= 1'b0;
            tag_mem[i]   <= '0;
            cnt_mem[i]   <= CNT_WNT;
         end
      end else if (is_br_check) begin
         valid_mem[check_idx] <= 1'b1;
         tag_mem[check_idx]   <= check_tag;
         cnt_mem[check_idx]   <= new_cnt;
      end
   end

   // Statistics: count resolved branches and wrong guesses, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (is_br_check) begin
         branch_count <= branch_count + CNT_WIDTH'(1);
         if (pred_taken_check != br_taken_check)
            mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Directed self-checking bench for branch_predictor (LINES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_guess = '0;
   logic        is_br_guess = 1'b0;
   logic        pred_taken;
   logic [31:0] pc_check = '0;
   logic        is_br_check = 1'b0;
   logic        br_taken_check = 1'b0;
   logic        pred_taken_check = 1'b0;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int checks = 0;
   int failures = 0;

   branch_predictor #(.PC_WIDTH(32), .LINES(8), .CNT_WIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_guess         (pc_guess),
      .is_br_guess      (is_br_guess),
      .pred_taken       (pred_taken),
      .pc_check         (pc_check),
      .is_br_check      (is_br_check),
      .br_taken_check   (br_taken_check),
      .pred_taken_check (pred_taken_check),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   // Stimulus helpers (no comparisons inside)
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_check(input logic [31:0] pc, input logic taken, input logic pt);
      @(negedge clk);
      pc_check         = pc;
      is_br_check      = 1'b1;
      br_taken_check   = taken;
      pred_taken_check = pt;
      @(posedge clk);
      #1;
      is_br_check = 1'b0;
   endtask

   task automatic set_guess(input logic [31:0] pc, input logic br);
      pc_guess    = pc;
      is_br_guess = br;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_guess_100 got=%b exp=0", pred_taken); end
      set_guess(32'hFFFF_FFFC, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_guess_top got=%b exp=0", pred_taken); end
      checks++; if (branch_count !== 32'd0) begin failures++; $display("FAIL reset_branch_count got=%0d exp=0", branch_count); end
      checks++; if (mispredict_count !== 32'd0) begin failures++; $display("FAIL reset_mispredict_count got=%0d exp=0", mispredict_count); end
   endtask

   task automatic test_train_low();
      do_reset();
      do_check(32'h100, 1'b1, 1'b0);          // allocate -> 10
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%b exp=1", pred_taken); end
      set_guess(32'h100, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL non_branch_guess got=%b exp=0", pred_taken); end
      do_check(32'h100, 1'b0, 1'b1);          // 10 -> 01
      do_check(32'h100, 1'b0, 1'b0);          // 01 -> 00
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL strong_nt got=%b exp=0", pred_taken); end
      do_check(32'h100, 1'b0, 1'b0);          // stays 00
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_low_guess got=%b exp=0", pred_taken); end
      do_check(32'h100, 1'b1, 1'b0);          // 00 -> 01
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_low_step got=%b exp=0", pred_taken); end
      do_check(32'h100, 1'b1, 1'b0);          // 01 -> 10
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL weak_nt_to_t got=%b exp=1", pred_taken); end
   endtask

   task automatic test_train_high();
      do_reset();
      for (int i = 0; i < 4; i++) do_check(32'h100, 1'b1, 1'b1);  // 10,11,11,11
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL strong_t got=%b exp=1", pred_taken); end
      do_check(32'h100, 1'b0, 1'b1);          // 11 -> 10
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_high_step got=%b exp=1", pred_taken); end
      do_check(32'h100, 1'b0, 1'b1);          // 10 -> 01
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL weak_t_to_nt got=%b exp=0", pred_taken); end
   endtask

   task automatic test_alias();
      do_reset();
      do_check(32'h100, 1'b1, 1'b0);          // idx0 tag 8 -> 10
      do_check(32'h104, 1'b1, 1'b0);          // idx1 tag 8 -> 10
      do_check(32'h120, 1'b0, 1'b0);          // idx0 tag 9 replaces -> 01
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_miss got=%b exp=0", pred_taken); end
      set_guess(32'h120, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_new_weak got=%b exp=0", pred_taken); end
      set_guess(32'h104, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_other_index got=%b exp=1", pred_taken); end
      set_guess(32'h107, 1'b1);               // low bits ignored
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL pc_low_bits got=%b exp=1", pred_taken); end
      do_check(32'h120, 1'b1, 1'b0);          // hit 01 -> 10
      set_guess(32'h120, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_new_train got=%b exp=1", pred_taken); end
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_still_miss got=%b exp=0", pred_taken); end
   endtask

   task automatic test_same_cycle();
      logic exp_fwd;
`ifdef BP_FWD_EN
      exp_fwd = 1'b1;
`else
      exp_fwd = 1'b0;
`endif
      do_reset();
      do_check(32'h100, 1'b0, 1'b0);          // allocate -> 01
      do_check(32'h104, 1'b1, 1'b0);          // idx1 -> 10
      @(negedge clk);
      pc_check = 32'h100; is_br_check = 1'b1; br_taken_check = 1'b1; pred_taken_check = 1'b0;
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== exp_fwd) begin failures++; $display("FAIL same_cycle_guess got=%b exp=%b", pred_taken, exp_fwd); end
      set_guess(32'h104, 1'b1);               // different index, parallel
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL parallel_guess got=%b exp=1", pred_taken); end
      @(posedge clk);
      #1;
      is_br_check = 1'b0;
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL same_cycle_after got=%b exp=1", pred_taken); end
   endtask

   task automatic test_stats();
      logic [31:0] pcs [10];
      logic        tk  [10];
      logic        pt  [10];
      pcs = '{32'h100, 32'h104, 32'h100, 32'h208, 32'h100, 32'h10C, 32'h300, 32'h104, 32'h100, 32'h110};
      tk  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      pt  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};  // mismatches at 0,4,6
      do_reset();
      for (int i = 0; i < 10; i++) do_check(pcs[i], tk[i], pt[i]);
      // non-branch with a mismatch must not count
      @(negedge clk);
      pc_check = 32'h100; is_br_check = 1'b0; br_taken_check = 1'b1; pred_taken_check = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (branch_count !== 32'd10) begin failures++; $display("FAIL branch_count got=%0d exp=10", branch_count); end
      checks++; if (mispredict_count !== 32'd3) begin failures++; $display("FAIL mispredict_count got=%0d exp=3", mispredict_count); end
      // reset concurrent with a check dominates
      do_check(32'h200, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      pc_check = 32'h204; is_br_check = 1'b1; br_taken_check = 1'b1; pred_taken_check = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      is_br_check = 1'b0;
      checks++; if (branch_count !== 32'd0) begin failures++; $display("FAIL rst_branch_count got=%0d exp=0", branch_count); end
      checks++; if (mispredict_count !== 32'd0) begin failures++; $display("FAIL rst_mispredict_count got=%0d exp=0", mispredict_count); end
      set_guess(32'h200, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_guess_200 got=%b exp=0", pred_taken); end
      set_guess(32'h204, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_guess_204 got=%b exp=0", pred_taken); end
      set_guess(32'h100, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_guess_100 got=%b exp=0", pred_taken); end
   endtask

   initial begin
      test_reset();
      test_train_low();
      test_train_high();
      test_alias();
      test_same_cycle();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
